threshold_detector: RTL and testbench
=====================================

# threshold_detector

Downstream stage of the moving-average filter. Compares the smoothed sample stream against a high/low hysteresis threshold pair and qualifies events with a consecutive-sample confirmation count. It runs a holdoff period after each event. Each completed event is reported (length, optional peak) through a valid/ready register to the control logic.

## Interface
Parameters:
- SIZE_DATA, default package_settings::SIZE_DATA: sample width, signed two's complement.
- SIZE_COUNT, default package_settings::SIZE_COUNT (8): width of confirm/holdoff/length counters.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- input_data  in  SIZE_DATA  signed smoothed sample from the moving-average output.
- input_valid  in  1  qualifies input_data. Cycles without it change no counter or state.
- threshold_high  in  SIZE_DATA  signed entry threshold.
- threshold_low  in  SIZE_DATA  signed exit threshold.
- confirm_count  in  SIZE_COUNT  consecutive samples > threshold_high required; 0 treated as 1.
- holdoff_count  in  SIZE_COUNT  valid samples ignored after event end; 0 = no holdoff.
- event_start  out  1  one-cycle pulse on event confirmation.
- event_end  out  1  one-cycle pulse on event exit.
- event_active  out  1  high while in ACTIVE.
- event_valid  out  1  report pending.
- event_ready  in  1  report consumer accepts when event_valid && event_ready.
- event_length  out  SIZE_COUNT  report: event length in valid samples, saturating.
- event_overflow  out  1  sticky: a report was dropped.
- peak_data  out  SIZE_DATA  report: maximum sample of the event (THRESHOLD_DETECTOR_PEAK_EN only).

## Operation
- FSM states: IDLE, ARMING, ACTIVE, HOLDOFF. Reset state is IDLE. All outputs reset to 0.
- Comparisons are signed and strict: "above" means input_data > threshold_high; "below" means input_data < threshold_low. Thresholds are used live each cycle.
- IDLE, on a valid sample above threshold:
  - effective confirm 1: go to ACTIVE, with length=1.
  - otherwise: go to ARMING, with cnt=1.
- confirm_count and holdoff_count are latched when ARMING and HOLDOFF are entered.
- ARMING, on a valid sample:
  - above and cnt+1 == confirm: go to ACTIVE, with length=confirm.
  - above otherwise: cnt+1.
  - not above: go to IDLE, cnt=0, no event.
- ACTIVE:
  - Valid sample not below: length+1, saturating at all-ones.
  - Valid sample below: pulse event_end and load the report (length, peak).
  - After the exit sample, go to HOLDOFF, or to IDLE if holdoff is 0.
  - The exit sample is not counted in the length.
- HOLDOFF: counts valid samples, ignoring their values. After holdoff_count of them, go to IDLE. The next valid sample is evaluated in IDLE.
- Report register:
  - Loaded at event end and sets event_valid. Held stable until accepted.
  - New end while pending and not accepted in the same cycle: old report kept, event_overflow set.
  - Acceptance in the same cycle as a new end: new report loaded, event_valid stays 1, no overflow.
  - event_overflow is cleared only by reset.
- threshold_low > threshold_high is legal. The FSM follows the rules above unchanged.

## Timing
- All outputs are registered.
- event_start, event_active rise, and event_end each occur 1 cycle after the qualifying valid sample's clock edge.
- event_valid rises in the same cycle as event_end. It falls the cycle after acceptance unless a new report is loaded.
- Reset mid-event: outputs go to 0 asynchronously. No event_end, no report. The FSM restarts in IDLE on the first edge after release.
- Throughput: one sample per cycle, no backpressure on input_data. Report backpressure never stalls the FSM.

## Configuration
- THRESHOLD_DETECTOR_PEAK_EN defined:
  - The peak_data port and peak register exist.
  - Peak = maximum signed valid sample from the first above-threshold sample (ARMING/IDLE entry) through the last ACTIVE sample.
  - It is captured with event_length.
- Undefined: the peak_data port and its logic are absent. All other behaviour is identical.

## Structure
- package_settings gains SIZE_COUNT and the typedef enum logic [1:0] threshold_state_t {IDLE, ARMING, ACTIVE, HOLDOFF}. The module uses the existing SIZE_DATA.
- One sub-module, threshold_event_report: a valid/ready holding register with overflow flag, parameterised by payload width.

## Test plan
Common setup: high=100, low=50, confirm=3, holdoff=2, event_ready=1 unless stated.
- Samples 0,120,130,140 -> event_start and event_active 1 cycle after the 140 sample; none earlier.
- Samples 120,130,90,120 -> no event_start; FSM returns to IDLE after 90, and ARMING restarts at the second 120.
- Samples 120,130,140,110,60,40 -> event_end 1 cycle after 40; event_valid=1, event_length=5, peak_data=140 (macro on).
- After the previous exit, samples 200,200,200,200,200 -> the first two are ignored; event_start 1 cycle after the fifth 200.
- event_ready=0 across two complete events -> event_length holds the first event's value and event_overflow=1. Raising event_ready clears event_valid next cycle; event_overflow stays 1.
- reset low during ACTIVE -> all outputs 0 immediately, no event_end. SIZE_COUNT=8 with 300 active samples -> event_length=255.

Source files
------------

// File: rtl/package_settings.sv
// Shared sizes and state encoding for the sample-processing chain.
package package_settings;

   localparam int SIZE_DATA  = 16;
   localparam int SIZE_COUNT = 8;

   typedef enum logic [1:0] {
      IDLE,
      ARMING,
      ACTIVE,
      HOLDOFF
   } threshold_state_t;

endpackage

// File: rtl/threshold_event_report.sv
// Valid/ready holding register for completed-event reports with a sticky drop flag.
module threshold_event_report #(
   parameter int SIZE_PAYLOAD = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [SIZE_PAYLOAD-1:0] load_payload,
   input  logic                    ready,
   output logic                    valid,
   output logic [SIZE_PAYLOAD-1:0] payload,
   output logic                    overflow
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid    <= 1'b0;
         payload  <= '0;
         overflow <= 1'b0;
      end else if (load) begin
         // A report accepted on this edge frees the slot for the new one.
         if (!valid || ready) begin
            payload <= load_payload;
            valid   <= 1'b1;
         end else begin
            overflow <= 1'b1;
         end
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/threshold_detector.sv
// Hysteresis threshold event detector with confirmation, holdoff and report register.
// Optional peak capture is enabled by defining THRESHOLD_DETECTOR_PEAK_EN.
module threshold_detector
   import package_settings::*;
#(
   parameter int SIZE_DATA  = package_settings::SIZE_DATA,
   parameter int SIZE_COUNT = package_settings::SIZE_COUNT
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic signed [SIZE_DATA-1:0]  input_data,
   input  logic                         input_valid,
   input  logic signed [SIZE_DATA-1:0]  threshold_high,
   input  logic signed [SIZE_DATA-1:0]  threshold_low,
   input  logic [SIZE_COUNT-1:0]        confirm_count,
   input  logic [SIZE_COUNT-1:0]        holdoff_count,
   output logic                         event_start,
   output logic                         event_end,
   output logic                         event_active,
   output logic                         event_valid,
   input  logic                         event_ready,
   output logic [SIZE_COUNT-1:0]        event_length,
`ifdef THRESHOLD_DETECTOR_PEAK_EN
   output logic signed [SIZE_DATA-1:0]  peak_data,
`endif
   output logic                         event_overflow
);

`ifdef THRESHOLD_DETECTOR_PEAK_EN
   localparam int SIZE_PAYLOAD = SIZE_COUNT + SIZE_DATA;
`else
   localparam int SIZE_PAYLOAD = SIZE_COUNT;
`endif

   function automatic logic [SIZE_COUNT-1:0] sat_inc(input logic [SIZE_COUNT-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic signed [SIZE_DATA-1:0] peak_max(
      input logic signed [SIZE_DATA-1:0] a,
      input logic signed [SIZE_DATA-1:0] b);
      return (b > a) ? b : a;
   endfunction

   threshold_state_t        state, state_nxt;
   logic [SIZE_COUNT-1:0]   cnt, cnt_nxt;
   logic [SIZE_COUNT-1:0]   confirm_lat, confirm_nxt;
   logic [SIZE_COUNT-1:0]   holdoff_lat, holdoff_nxt;
   logic [SIZE_COUNT-1:0]   length, length_nxt;
   logic [SIZE_COUNT-1:0]   confirm_eff;
   logic                    start_nxt, end_nxt;
   logic                    above, below;
   logic signed [SIZE_DATA-1:0] peak, peak_nxt;
   logic [SIZE_PAYLOAD-1:0] load_payload, payload;

   assign above       = input_data > threshold_high;
   assign below       = input_data < threshold_low;
   assign confirm_eff = (confirm_count == '0) ? SIZE_COUNT'(1) : confirm_count;

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      confirm_nxt = confirm_lat;
      holdoff_nxt = holdoff_lat;
      length_nxt  = length;
      peak_nxt    = peak;
      start_nxt   = 1'b0;
      end_nxt     = 1'b0;
      if (input_valid) begin
         case (state)
            IDLE: begin
               if (above) begin
                  peak_nxt = input_data;
                  if (confirm_eff == SIZE_COUNT'(1)) begin
                     state_nxt  = ACTIVE;
                     length_nxt = SIZE_COUNT'(1);
                     start_nxt  = 1'b1;
                  end else begin
                     state_nxt   = ARMING;
                     cnt_nxt     = SIZE_COUNT'(1);
                     confirm_nxt = confirm_eff;
                  end
               end
            end
            ARMING: begin
               if (above) begin
                  peak_nxt = peak_max(peak, input_data);
                  if (cnt + 1'b1 == confirm_lat) begin
                     state_nxt  = ACTIVE;
                     length_nxt = confirm_lat;
                     cnt_nxt    = '0;
                     start_nxt  = 1'b1;
                  end else begin
                     cnt_nxt = cnt + 1'b1;
                  end
               end else begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end
            end
            ACTIVE: begin
               // The exit sample closes the event but is not part of it.
               if (below) begin
                  end_nxt = 1'b1;
                  cnt_nxt = '0;
                  if (holdoff_count == '0) begin
                     state_nxt = IDLE;
                  end else begin
                     state_nxt   = HOLDOFF;
                     holdoff_nxt = holdoff_count;
                  end
               end else begin
                  length_nxt = sat_inc(length);
                  peak_nxt   = peak_max(peak, input_data);
               end
            end
            HOLDOFF: begin
               if (cnt + 1'b1 == holdoff_lat) begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         cnt          <= '0;
         confirm_lat  <= '0;
         holdoff_lat  <= '0;
         length       <= '0;
         peak         <= '0;
         event_start  <= 1'b0;
         event_end    <= 1'b0;
         event_active <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         confirm_lat  <= confirm_nxt;
         holdoff_lat  <= holdoff_nxt;
         length       <= length_nxt;
         peak         <= peak_nxt;
         event_start  <= start_nxt;
         event_end    <= end_nxt;
         event_active <= (state_nxt == ACTIVE);
      end
   end

`ifdef THRESHOLD_DETECTOR_PEAK_EN
   assign load_payload = {length, peak};
   assign event_length = payload[SIZE_PAYLOAD-1 -: SIZE_COUNT];
   assign peak_data    = $signed(payload[SIZE_DATA-1:0]);
`else
   assign load_payload = length;
   assign event_length = payload;
`endif

   threshold_event_report #(
      .SIZE_PAYLOAD (SIZE_PAYLOAD)
   ) u_report (
      .clk          (clk),
      .reset        (reset),
      .load         (end_nxt),
      .load_payload (load_payload),
      .ready        (event_ready),
      .valid        (event_valid),
      .payload      (payload),
      .overflow     (event_overflow)
   );

endmodule

// File: tb/tb_threshold_detector.sv
// Directed bench for threshold_detector: vector table plus multi-cycle corner sequences.
module tb_threshold_detector;

   logic               clk = 1'b0;
   logic               reset;
   logic signed [15:0] input_data;
   logic               input_valid;
   logic signed [15:0] threshold_high;
   logic signed [15:0] threshold_low;
   logic [7:0]         confirm_count;
   logic [7:0]         holdoff_count;
   logic               event_start;
   logic               event_end;
   logic               event_active;
   logic               event_valid;
   logic               event_ready;
   logic [7:0]         event_length;
   logic               event_overflow;
`ifdef THRESHOLD_DETECTOR_PEAK_EN
   logic signed [15:0] peak_data;
`endif

   int total = 0;
   int bad   = 0;

   threshold_detector #(
      .SIZE_DATA  (16),
      .SIZE_COUNT (8)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .input_data     (input_data),
      .input_valid    (input_valid),
      .threshold_high (threshold_high),
      .threshold_low  (threshold_low),
      .confirm_count  (confirm_count),
      .holdoff_count  (holdoff_count),
      .event_start    (event_start),
      .event_end      (event_end),
      .event_active   (event_active),
      .event_valid    (event_valid),
      .event_ready    (event_ready),
      .event_length   (event_length),
`ifdef THRESHOLD_DETECTOR_PEAK_EN
      .peak_data      (peak_data),
`endif
      .event_overflow (event_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic vld;
      int   data;
      logic st;
      logic en;
      logic act;
      logic ev;
      int   len;
      int   pk;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic vld, input int data, input logic st, input logic en,
                      input logic act, input logic ev, input int len, input int pk);
      vec_t v;
      v.vld = vld; v.data = data; v.st = st; v.en = en;
      v.act = act; v.ev = ev; v.len = len; v.pk = pk;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic step(input logic v, input int d);
      input_valid = v;
      input_data  = 16'(d);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      input_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic check_peak(input string nm, input int exp);
`ifdef THRESHOLD_DETECTOR_PEAK_EN
      chk(nm, 32'(peak_data), 32'(exp));
`endif
   endtask

   initial begin
      reset          = 1'b0;
      input_valid    = 1'b0;
      input_data     = '0;
      threshold_high = 16'sd100;
      threshold_low  = 16'sd50;
      confirm_count  = 8'd3;
      holdoff_count  = 8'd2;
      event_ready    = 1'b1;

      //      vld data  st en act ev len pk
      add(1,   0,   0, 0, 0, 0, 0, 0);
      add(1, 120,   0, 0, 0, 0, 0, 0);
      add(0,  30,   0, 0, 0, 0, 0, 0);
      add(1, 130,   0, 0, 0, 0, 0, 0);
      add(1, 140,   1, 0, 1, 0, 0, 0);
      add(1, 110,   0, 0, 1, 0, 0, 0);
      add(1,  60,   0, 0, 1, 0, 0, 0);
      add(1,  40,   0, 1, 0, 1, 5, 140);
      add(1, 200,   0, 0, 0, 0, 5, 0);
      add(1, 200,   0, 0, 0, 0, 5, 0);
      add(1, 200,   0, 0, 0, 0, 5, 0);
      add(1, 200,   0, 0, 0, 0, 5, 0);
      add(1, 200,   1, 0, 1, 0, 5, 0);
      add(1,  40,   0, 1, 0, 1, 3, 200);
      add(1,   0,   0, 0, 0, 0, 3, 0);
      add(1,   0,   0, 0, 0, 0, 3, 0);
      add(1, 120,   0, 0, 0, 0, 3, 0);
      add(1, 130,   0, 0, 0, 0, 3, 0);
      add(1,  90,   0, 0, 0, 0, 3, 0);
      add(1, 120,   0, 0, 0, 0, 3, 0);
      add(1, 130,   0, 0, 0, 0, 3, 0);
      add(1, 140,   1, 0, 1, 0, 3, 0);
      add(1,  50,   0, 0, 1, 0, 3, 0);
      add(1, 100,   0, 0, 1, 0, 3, 0);
      add(1,  49,   0, 1, 0, 1, 5, 140);
      add(1, 101,   0, 0, 0, 0, 5, 0);
      add(1,   0,   0, 0, 0, 0, 5, 0);
      add(1, 100,   0, 0, 0, 0, 5, 0);
      add(1, 101,   0, 0, 0, 0, 5, 0);
      add(1, 101,   0, 0, 0, 0, 5, 0);
      add(1, 101,   1, 0, 1, 0, 5, 0);
      add(1,  10,   0, 1, 0, 1, 3, 101);
      add(1,   0,   0, 0, 0, 0, 3, 0);
      add(1,   0,   0, 0, 0, 0, 3, 0);

      // Reset state
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("reset_outputs",
          {26'd0, event_start, event_end, event_active, event_valid, event_overflow, 1'b0},
          32'd0);
      chk("reset_length", 32'(event_length), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].vld, vecs[i].data);
         chk($sformatf("vec%0d", i),
             {20'd0, event_start, event_end, event_active, event_valid, event_length},
             {20'd0, vecs[i].st, vecs[i].en, vecs[i].act, vecs[i].ev, 8'(vecs[i].len)});
         if (vecs[i].ev)
            check_peak($sformatf("vec%0d_peak", i), vecs[i].pk);
      end

      // Backpressure across two events: second report dropped
      do_reset();
      event_ready = 1'b0;
      step(1, 120); step(1, 130); step(1, 140); step(1, 30);
      chk("bp_first_valid", 32'(event_valid), 32'd1);
      step(1, 0); step(1, 0);
      step(1, 150); step(1, 150); step(1, 150); step(1, 150); step(1, 30);
      chk("bp_second_end", 32'(event_end), 32'd1);
      chk("bp_overflow", 32'(event_overflow), 32'd1);
      chk("bp_len_held", 32'(event_length), 32'd3);
      check_peak("bp_peak_held", 140);
      step(1, 0); step(1, 0);
      event_ready = 1'b1;
      step(0, 0);
      chk("bp_valid_cleared", 32'(event_valid), 32'd0);
      chk("bp_overflow_sticky", 32'(event_overflow), 32'd1);
      chk("bp_len_after", 32'(event_length), 32'd3);

      // Acceptance on the same edge as a new report
      do_reset();
      event_ready = 1'b0;
      step(1, 120); step(1, 130); step(1, 140); step(1, 30);
      step(1, 0); step(1, 0);
      step(1, 120); step(1, 130); step(1, 140); step(1, 150);
      event_ready = 1'b1;
      step(1, 30);
      chk("same_valid", 32'(event_valid), 32'd1);
      chk("same_len", 32'(event_length), 32'd4);
      chk("same_no_overflow", 32'(event_overflow), 32'd0);
      check_peak("same_peak", 150);
      step(0, 0);
      chk("same_valid_drop", 32'(event_valid), 32'd0);

      // Reset while ACTIVE
      do_reset();
      step(1, 120); step(1, 130); step(1, 140);
      chk("rst_pre_active", 32'(event_active), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("rst_async_outputs",
          {27'd0, event_start, event_end, event_active, event_valid, event_overflow},
          32'd0);
      step(1, 30);
      chk("rst_no_end", 32'(event_end), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      step(1, 120); step(1, 130);
      chk("rst_no_early_start", {30'd0, event_start, event_active}, 32'd0);
      step(1, 140);
      chk("rst_restart", {30'd0, event_start, event_active}, 32'd3);

      // Confirm 0 acts as 1, holdoff 0, length saturation
      do_reset();
      confirm_count = 8'd0;
      holdoff_count = 8'd0;
      step(1, 120);
      chk("sat_start", 32'(event_start), 32'd1);
      for (int i = 0; i < 299; i++) step(1, 120);
      chk("sat_active", 32'(event_active), 32'd1);
      step(1, 30);
      chk("sat_end", 32'(event_end), 32'd1);
      chk("sat_len", 32'(event_length), 32'd255);
      check_peak("sat_peak", 120);
      step(1, 120);
      chk("nohold_restart", 32'(event_start), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
